// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse-train generator and anything that consumes
// its output (e.g. the coincidence-counter bench).
//   - state_t           : generator FSM encoding (IDLE / RUN)
//   - PTG_CW / PTG_LW   : default counter width and LFSR width
//   - PTG_SEED_DFLT     : LFSR value after reset and when a zero seed is given
//   - PTG_TAP_MASK      : Galois tap mask for x^16+x^14+x^13+x^11+1
//   - lfsr_next()       : one Galois LFSR step
package pulse_train_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int          PTG_CW        = 13;
  localparam int          PTG_LW        = 16;
  localparam logic [15:0] PTG_SEED_DFLT = 16'hACE1;
  localparam logic [15:0] PTG_TAP_MASK  = 16'hB400;

  // Right-shifting Galois step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? PTG_TAP_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/pulse_train_gen_lfsr16.sv
// 16-bit Galois LFSR used as the background-pulse source.
// Ports:
//   clk     : clock
//   reset   : synchronous, active-low; state returns to RST_VAL
//   load    : load seed (takes priority over advance)
//   seed    : value loaded when load is high
//   advance : step the register one position
//   state   : current LFSR contents
module lfsr16
  import pulse_train_gen_pkg::*;
#(
  parameter logic [15:0] RST_VAL = PTG_SEED_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RST_VAL;
    end else if (load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable neutron pulse-train emulator. Produces single-cycle pulses made
// of periodic primaries, a burst of correlated follow-ups after each primary,
// and optional LFSR-driven uncorrelated background pulses.
// Ports:
//   clk_1mhz       : 1 MHz system clock
//   reset_ip       : synchronous, active-low reset
//   run_ip         : level; high = generate, low = return to IDLE
//   period_ip      : cycles between primaries (values < 2 act as 2)
//   burst_len_ip   : follow-up pulses per event (0..15)
//   gap_ip         : cycles between pulses inside a burst (0 acts as 1)
//   bg_thresh_ip   : background pulse when lfsr < threshold (0 disables)
//   seed_ip        : LFSR seed loaded on start (0 selects SEED_DFLT)
//   pulse_op       : registered single-cycle pulse
//   busy_op        : high while not IDLE
//   event_count_op : primaries emitted, wraps
//   pulse_count_op : cycles with pulse_op high, wraps
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int          CW        = PTG_CW,
  parameter int          LW        = PTG_LW,
  parameter logic [15:0] SEED_DFLT = PTG_SEED_DFLT
) (
  input  logic          clk_1mhz,
  input  logic          reset_ip,
  input  logic          run_ip,
  input  logic [CW-1:0] period_ip,
  input  logic [3:0]    burst_len_ip,
  input  logic [7:0]    gap_ip,
  input  logic [LW-1:0] bg_thresh_ip,
  input  logic [LW-1:0] seed_ip,
  output logic          pulse_op,
  output logic          busy_op,
  output logic [CW-1:0] event_count_op,
  output logic [CW-1:0] pulse_count_op
);

  localparam logic [CW-1:0] PERIOD_MIN = CW'(2);

  state_t        state, state_next;

  // Configuration captured at start
  logic [CW-1:0] period_q;
  logic [3:0]    burst_q;
  logic [7:0]    gap_q;
  logic [LW-1:0] bg_thresh_q;

  // Sequencing counters
  logic [CW-1:0] period_cnt, period_cnt_next;
  logic [7:0]    gap_cnt, gap_cnt_next;
  logic [3:0]    rem, rem_next;

  logic [CW-1:0] period_eff;
  logic [7:0]    gap_eff;
  logic [LW-1:0] seed_eff;
  logic [LW-1:0] lfsr_state;

  logic          start;
  logic          primary, follow, bg_hit;
  logic          lfsr_load, lfsr_adv;
  logic          pulse_next, busy_next;

  assign period_eff = (period_ip < PERIOD_MIN) ? PERIOD_MIN : period_ip;
  assign gap_eff    = (gap_ip == 8'd0) ? 8'd1 : gap_ip;
  assign seed_eff   = (seed_ip == '0) ? SEED_DFLT : seed_ip;
  assign start      = (state == ST_IDLE) && run_ip;

  lfsr16 #(
    .RST_VAL (SEED_DFLT)
  ) u_lfsr (
    .clk     (clk_1mhz),
    .reset   (reset_ip),
    .load    (lfsr_load),
    .seed    (seed_eff),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // Next-state and pulse-source decode.
  // period_cnt counts down to 0 and then fires a primary; gap_cnt does the
  // same for follow-ups. Both are reloaded with (value-1) so that a count of
  // N cycles lands exactly N edges after the previous pulse.
  always_comb begin
    state_next      = state;
    period_cnt_next = period_cnt;
    gap_cnt_next    = gap_cnt;
    rem_next        = rem;
    primary         = 1'b0;
    follow          = 1'b0;
    bg_hit          = 1'b0;
    lfsr_load       = 1'b0;
    lfsr_adv        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (run_ip) begin
          state_next      = ST_RUN;
          lfsr_load       = 1'b1;
          primary         = 1'b1;
          period_cnt_next = period_eff - CW'(1);
          gap_cnt_next    = gap_eff - 8'd1;
          rem_next        = burst_len_ip;
        end
      end
      ST_RUN: begin
        if (!run_ip) begin
          state_next = ST_IDLE;
          rem_next   = 4'd0;
        end else begin
          lfsr_adv = 1'b1;
          bg_hit   = (lfsr_state < bg_thresh_q);
          if (period_cnt == '0) begin
            // A primary always wins: any unfinished burst is dropped here.
            primary         = 1'b1;
            period_cnt_next = period_q - CW'(1);
            gap_cnt_next    = gap_q - 8'd1;
            rem_next        = burst_q;
          end else begin
            period_cnt_next = period_cnt - CW'(1);
            if (rem != 4'd0) begin
              if (gap_cnt == 8'd0) begin
                follow       = 1'b1;
                rem_next     = rem - 4'd1;
                gap_cnt_next = gap_q - 8'd1;
              end else begin
                gap_cnt_next = gap_cnt - 8'd1;
              end
            end
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    pulse_next = primary | follow | bg_hit;
    busy_next  = (state_next == ST_RUN);
  end

  // Control state and outputs
  always_ff @(posedge clk_1mhz) begin
    if (!reset_ip) begin
      state          <= ST_IDLE;
      rem            <= 4'd0;
      pulse_op       <= 1'b0;
      busy_op        <= 1'b0;
      event_count_op <= '0;
      pulse_count_op <= '0;
    end else begin
      state          <= state_next;
      rem            <= rem_next;
      pulse_op       <= pulse_next;
      busy_op        <= busy_next;
      event_count_op <= event_count_op + CW'(primary);
      pulse_count_op <= pulse_count_op + CW'(pulse_next);
    end
  end

  // Configuration and down-counters are always (re)loaded on start,
  // so they carry no reset.
  always_ff @(posedge clk_1mhz) begin
    period_cnt <= period_cnt_next;
    gap_cnt    <= gap_cnt_next;
    if (start) begin
      period_q    <= period_eff;
      burst_q     <= burst_len_ip;
      gap_q       <= gap_eff;
      bg_thresh_q <= bg_thresh_ip;
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  logic        clk_1mhz;
  logic        reset_ip;
  logic        run_ip;
  logic [12:0] period_ip;
  logic [3:0]  burst_len_ip;
  logic [7:0]  gap_ip;
  logic [15:0] bg_thresh_ip;
  logic [15:0] seed_ip;
  logic        pulse_op;
  logic        busy_op;
  logic [12:0] event_count_op;
  logic [12:0] pulse_count_op;

  pulse_train_gen dut (
    .clk_1mhz       (clk_1mhz),
    .reset_ip       (reset_ip),
    .run_ip         (run_ip),
    .period_ip      (period_ip),
    .burst_len_ip   (burst_len_ip),
    .gap_ip         (gap_ip),
    .bg_thresh_ip   (bg_thresh_ip),
    .seed_ip        (seed_ip),
    .pulse_op       (pulse_op),
    .busy_op        (busy_op),
    .event_count_op (event_count_op),
    .pulse_count_op (pulse_count_op)
  );

  initial clk_1mhz = 1'b0;
  always #500 clk_1mhz = ~clk_1mhz;

  typedef struct packed {
    logic        pulse;
    logic        busy;
    logic [12:0] ev;
    logic [12:0] pc;
  } obs_t;

  obs_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  bit          m_run = 1'b0;
  int          m_n, m_p, m_b, m_g;
  logic [15:0] m_thr, m_lfsr;
  logic [12:0] m_ev, m_pc;

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ 16'hB400;
    return s;
  endfunction

  // Drive one edge worth of inputs, push the expected post-edge view, then
  // advance to just after the edge. Pulse timing is derived from the offset
  // within the current period window rather than from running counters.
  task automatic step(input logic run, input logic rst_n);
    obs_t e;
    logic prim, fol, bg;
    int   o;
    reset_ip = rst_n;
    run_ip   = run;
    e.pulse  = 1'b0;
    if (!rst_n) begin
      m_run  = 1'b0;
      m_ev   = '0;
      m_pc   = '0;
      m_lfsr = 16'hACE1;
    end else if (!m_run) begin
      if (run) begin
        m_run  = 1'b1;
        m_p    = (period_ip < 13'd2) ? 2 : int'(period_ip);
        m_b    = int'(burst_len_ip);
        m_g    = (gap_ip == 8'd0) ? 1 : int'(gap_ip);
        m_thr  = bg_thresh_ip;
        m_lfsr = (seed_ip == 16'd0) ? 16'hACE1 : seed_ip;
        m_n    = 1;
        e.pulse = 1'b1;
        m_ev   = m_ev + 13'd1;
      end
    end else if (!run) begin
      m_run = 1'b0;
    end else begin
      m_n    = m_n + 1;
      o      = (m_n - 1) % m_p;
      prim   = (o == 0);
      fol    = (o != 0) && (o % m_g == 0) && (o / m_g <= m_b);
      bg     = (m_lfsr < m_thr);
      m_lfsr = lfsr_ref(m_lfsr);
      e.pulse = prim | fol | bg;
      if (prim) m_ev = m_ev + 13'd1;
    end
    if (e.pulse) m_pc = m_pc + 13'd1;
    e.busy = m_run;
    e.ev   = m_ev;
    e.pc   = m_pc;
    sb.push_back(e);
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic set_cfg(input logic [12:0] p, input logic [3:0] b, input logic [7:0] g,
                         input logic [15:0] thr, input logic [15:0] seed);
    period_ip    = p;
    burst_len_ip = b;
    gap_ip       = g;
    bg_thresh_ip = thr;
    seed_ip      = seed;
  endtask

  task automatic test_reset();
    obs_t e, got;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      e   = sb.pop_front();
      got = {pulse_op, busy_op, event_count_op, pulse_count_op};
      n_tests++;
      if (got !== e || got !== 28'd0) begin
        $display("FAIL reset cyc %0d: got p=%b b=%b ev=%0d pc=%0d, want all zero",
                 i, got.pulse, got.busy, got.ev, got.pc);
        n_fail++;
      end
    end
    step(1'b0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_basic_bursts();
    obs_t e, got;
    set_cfg(13'd20, 4'd2, 8'd3, 16'd0, 16'd0);
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 1'b1);
      e   = sb.pop_front();
      got = {pulse_op, busy_op, event_count_op, pulse_count_op};
      n_tests++;
      if (got !== e) begin
        $display("FAIL basic cyc %0d: got p=%b b=%b ev=%0d pc=%0d, want p=%b b=%b ev=%0d pc=%0d",
                 i + 1, got.pulse, got.busy, got.ev, got.pc, e.pulse, e.busy, e.ev, e.pc);
        n_fail++;
      end
    end
    n_tests++;
    if (event_count_op !== 13'd3 || pulse_count_op !== 13'd9) begin
      $display("FAIL basic_totals: got ev=%0d pc=%0d, want ev=3 pc=9",
               event_count_op, pulse_count_op);
      n_fail++;
    end
    step(1'b0, 1'b1);
    e   = sb.pop_front();
    got = {pulse_op, busy_op, event_count_op, pulse_count_op};
    n_tests++;
    if (got !== e) begin
      $display("FAIL basic_stop: got p=%b b=%b, want p=%b b=%b", got.pulse, got.busy, e.pulse, e.busy);
      n_fail++;
    end
  endtask

  task automatic test_truncation();
    obs_t e, got;
    set_cfg(13'd5, 4'd3, 8'd2, 16'd0, 16'd0);
    for (int i = 0; i < 26; i++) begin
      step(1'b1, 1'b1);
      // Inputs moved after start must have no effect until the next start
      if (i == 0) set_cfg(13'd9, 4'd7, 8'd1, 16'hFFFF, 16'h1234);
      e   = sb.pop_front();
      got = {pulse_op, busy_op, event_count_op, pulse_count_op};
      n_tests++;
      if (got !== e) begin
        $display("FAIL trunc cyc %0d: got p=%b b=%b ev=%0d pc=%0d, want p=%b b=%b ev=%0d pc=%0d",
                 i + 1, got.pulse, got.busy, got.ev, got.pc, e.pulse, e.busy, e.ev, e.pc);
        n_fail++;
      end
    end
    step(1'b0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_clamp();
    obs_t e, got;
    set_cfg(13'd1, 4'd1, 8'd0, 16'd0, 16'd0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1);
      e   = sb.pop_front();
      got = {pulse_op, busy_op, event_count_op, pulse_count_op};
      n_tests++;
      if (got !== e || pulse_op !== 1'b1) begin
        $display("FAIL clamp cyc %0d: got p=%b b=%b ev=%0d pc=%0d, want p=%b b=%b ev=%0d pc=%0d",
                 i + 1, got.pulse, got.busy, got.ev, got.pc, e.pulse, e.busy, e.ev, e.pc);
        n_fail++;
      end
    end
    step(1'b0, 1'b1);
    void'(sb.pop_front());
  endtask

  task automatic test_background();
    obs_t e, got;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) set_cfg(13'd8191, 4'd0, 8'd1, 16'hFFFF, 16'd0);
      else           set_cfg(13'd50, 4'd2, 8'd4, 16'h6000, 16'h0BAD);
      for (int i = 0; i < 200; i++) begin
        step(1'b1, 1'b1);
        e   = sb.pop_front();
        got = {pulse_op, busy_op, event_count_op, pulse_count_op};
        n_tests++;
        if (got !== e) begin
          $display("FAIL bg%0d cyc %0d: got p=%b b=%b ev=%0d pc=%0d, want p=%b b=%b ev=%0d pc=%0d",
                   pass, i + 1, got.pulse, got.busy, got.ev, got.pc, e.pulse, e.busy, e.ev, e.pc);
          n_fail++;
        end
      end
      step(1'b0, 1'b1);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_stop_restart();
    obs_t e, got;
    logic r;
    set_cfg(13'd10, 4'd3, 8'd2, 16'd0, 16'd0);
    // 5 running cycles (mid-burst), 4 stopped, 15 running, 2 stopped
    for (int i = 0; i < 26; i++) begin
      r = (i < 5) || (i >= 9 && i < 24);
      step(r, 1'b1);
      e   = sb.pop_front();
      got = {pulse_op, busy_op, event_count_op, pulse_count_op};
      n_tests++;
      if (got !== e) begin
        $display("FAIL stop_restart cyc %0d: got p=%b b=%b ev=%0d pc=%0d, want p=%b b=%b ev=%0d pc=%0d",
                 i + 1, got.pulse, got.busy, got.ev, got.pc, e.pulse, e.busy, e.ev, e.pc);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_midrun();
    obs_t e, got;
    logic rn, r;
    set_cfg(13'd10, 4'd3, 8'd2, 16'd0, 16'd0);
    // 3 running cycles, one reset edge with run held high, then idle
    for (int i = 0; i < 9; i++) begin
      rn = (i != 3);
      r  = (i <= 3);
      step(r, rn);
      e   = sb.pop_front();
      got = {pulse_op, busy_op, event_count_op, pulse_count_op};
      n_tests++;
      if (got !== e || (i >= 3 && got !== 28'd0)) begin
        $display("FAIL reset_midrun cyc %0d: got p=%b b=%b ev=%0d pc=%0d, want p=%b b=%b ev=%0d pc=%0d",
                 i + 1, got.pulse, got.busy, got.ev, got.pc, e.pulse, e.busy, e.ev, e.pc);
        n_fail++;
      end
    end
  endtask

  initial begin
    reset_ip = 1'b0;
    run_ip   = 1'b0;
    set_cfg(13'd0, 4'd0, 8'd0, 16'd0, 16'd0);
    m_ev   = '0;
    m_pc   = '0;
    m_lfsr = 16'hACE1;
    #200;
    test_reset();
    test_basic_bursts();
    test_truncation();
    test_clamp();
    test_background();
    test_stop_restart();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
